// File: rtl/seq_arith_unit.sv
// Sequential add/sub/multiply unit with valid/ready handshaking on both sides.
// Multiply is shift-add, one partial product per cycle; the result register only loads on completion.
module seq_arith_unit #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     op,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic           cin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result,
    output logic           cout,
    output logic           err
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [2*N-1:0]   result_q, result_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             accept_s;
    logic             handshake_s;
    logic [N:0]       sum_s;
    logic [N:0]       diff_s;
    logic [2*N-1:0]   pp_s;

    // State, datapath and handshake registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic, operation capture and multiply stepping
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        result_d    = result_q;
        cout_d      = cout_q;
        err_d       = err_q;

        accept_s    = in_valid & in_ready_q;
        handshake_s = out_valid_q & out_ready;
        sum_s       = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};
        diff_s      = {1'b0, x} + {1'b0, ~y} + {{N{1'b0}}, 1'b1};
        // Multiplicand is pre-shifted each step, so bit 0 of the multiplier selects it
        pp_s        = mplier_q[0] ? mcand_q : {(2*N){1'b0}};

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    case (op)
                        2'b00: begin
                            result_d = {{N{1'b0}}, sum_s[N-1:0]};
                            cout_d   = sum_s[N];
                            err_d    = 1'b0;
                            state_d  = S_DONE;
                        end
                        2'b01: begin
                            result_d = {{N{1'b0}}, diff_s[N-1:0]};
                            cout_d   = diff_s[N];
                            err_d    = 1'b0;
                            state_d  = S_DONE;
                        end
                        2'b10: begin
                            mcand_d  = {{N{1'b0}}, x};
                            mplier_d = y;
                            acc_d    = {(2*N){1'b0}};
                            cnt_d    = {CW{1'b0}};
                            err_d    = 1'b0;
                            state_d  = S_MUL;
                        end
                        default: begin
                            result_d = {(2*N){1'b0}};
                            cout_d   = 1'b0;
                            err_d    = 1'b1;
                            state_d  = S_DONE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d    = acc_q + pp_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    result_d = acc_q + pp_s;
                    cout_d   = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_MUL;
                end
            end
            S_DONE: begin
                if (handshake_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Scoreboard bench: directed N=8 vectors plus an exhaustive N=4 sweep against a reference model.
`timescale 1ns/1ps
module tb_seq_arith_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic        cout;
        logic        err;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic        rst8, in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, err8;
    logic [1:0]  op8;
    logic [7:0]  x8, y8;
    logic [15:0] result8;

    logic        rst4, in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, err4;
    logic [1:0]  op4;
    logic [3:0]  x4, y4;
    logic [7:0]  result4;

    seq_arith_unit #(.N(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .x(x8), .y(y8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .cout(cout8), .err(err8)
    );

    seq_arith_unit #(.N(4)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4), .op(op4),
        .x(x4), .y(y4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .result(result4), .cout(cout4), .err(err4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: got no response expected one at %0t", name, $time);
    endtask

    // Output monitor for the N=8 instance
    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst8 && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out8: got result 0x%0h expected no output", result8);
            end else begin
                e = q8.pop_front();
                check("result8", result8, e.res);
                check("cout8", cout8, e.cout);
                check("err8", err8, e.err);
            end
        end
    end

    // Output monitor for the N=4 instance
    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst4 && out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out4: got result 0x%0h expected no output", result4);
            end else begin
                e = q4.pop_front();
                check("result4", result4, e.res);
                check("cout4", cout4, e.cout);
                check("err4", err4, e.err);
            end
        end
    end

    task automatic issue8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [15:0] r, input logic co, input logic er);
        int t = 0;
        while (!in_ready8 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready8) begin
            fail("issue8_timeout");
            return;
        end
        q8.push_back(exp_t'{res: r, cout: co, err: er});
        op8 = o; x8 = a; y8 = b; cin8 = c; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic issue4(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                          input logic c, input logic [7:0] r, input logic co, input logic er);
        int t = 0;
        while (!in_ready4 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready4) begin
            fail("issue4_timeout");
            return;
        end
        q4.push_back(exp_t'{res: {8'h00, r}, cout: co, err: er});
        op4 = o; x4 = a; y4 = b; cin4 = c; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    task automatic wait_valid8();
        int t = 0;
        while (!out_valid8 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!out_valid8) fail("wait_valid8_timeout");
    endtask

    initial begin
        logic [3:0] xa, yb;
        logic       ci;
        logic [4:0] s;
        logic [7:0] r;
        logic       co, er;
        int         t;

        rst8 = 1'b1; in_valid8 = 1'b0; op8 = 2'b00; x8 = 8'h00; y8 = 8'h00; cin8 = 1'b0; out_ready8 = 1'b1;
        rst4 = 1'b1; in_valid4 = 1'b0; op4 = 2'b00; x4 = 4'h0; y4 = 4'h0; cin4 = 1'b0; out_ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready8, 1);
        check("rst_out_valid", out_valid8, 0);
        check("rst_result", result8, 0);
        check("rst_cout", cout8, 0);
        check("rst_err", err8, 0);
        rst8 = 1'b0; rst4 = 1'b0;

        // add 200+100+1, latency 1
        issue8(2'b00, 8'd200, 8'd100, 1'b1, 16'h002D, 1'b1, 1'b0);
        check("add_latency", out_valid8, 1);
        check("add_in_ready_low", in_ready8, 0);

        // sub in both directions
        issue8(2'b01, 8'd5, 8'd7, 1'b0, 16'h00FE, 1'b0, 1'b0);
        issue8(2'b01, 8'd7, 8'd5, 1'b1, 16'h0002, 1'b1, 1'b0);

        // mul 255*255 with exact latency
        issue8(2'b10, 8'd255, 8'd255, 1'b0, 16'hFE01, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k < 8) check("mul_latency_early", out_valid8, 0);
            else       check("mul_latency", out_valid8, 1);
        end
        issue8(2'b10, 8'd0, 8'd77, 1'b0, 16'h0000, 1'b0, 1'b0);

        // backpressure after 13*11
        wait_valid8();
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        issue8(2'b10, 8'd13, 8'd11, 1'b0, 16'h008F, 1'b0, 1'b0);
        wait_valid8();
        for (int k = 0; k < 5; k++) begin
            check("hold_result", result8, 16'h008F);
            check("hold_out_valid", out_valid8, 1);
            check("hold_in_ready", in_ready8, 0);
            @(posedge clk); #1;
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", in_ready8, 1);
        check("release_out_valid", out_valid8, 0);

        // reset in the middle of 12*12
        issue8(2'b10, 8'd12, 8'd12, 1'b0, 16'h0090, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid_mul_out_valid", out_valid8, 0);
        rst8 = 1'b1;
        q8.delete();
        @(posedge clk); #1;
        rst8 = 1'b0;
        check("mid_rst_out_valid", out_valid8, 0);
        check("mid_rst_result", result8, 0);
        check("mid_rst_in_ready", in_ready8, 1);
        issue8(2'b00, 8'd1, 8'd1, 1'b0, 16'h0002, 1'b0, 1'b0);

        // illegal op then an add that clears err
        issue8(2'b11, 8'd9, 8'd9, 1'b1, 16'h0000, 1'b0, 1'b1);
        check("illegal_latency", out_valid8, 1);
        check("illegal_err", err8, 1);
        issue8(2'b00, 8'd3, 8'd4, 1'b0, 16'h0007, 1'b0, 1'b0);
        check("err_cleared", err8, 0);

        // exhaustive N=4 sweep against a reference model
        for (int o = 0; o < 4; o++) begin
            for (int xi = 0; xi < 16; xi++) begin
                for (int yi = 0; yi < 16; yi++) begin
                    xa = 4'(xi);
                    yb = 4'(yi);
                    ci = xa[0] ^ yb[1];
                    er = 1'b0;
                    case (o)
                        0: begin
                            s  = {1'b0, xa} + {1'b0, yb} + {4'h0, ci};
                            r  = {4'h0, s[3:0]};
                            co = s[4];
                        end
                        1: begin
                            s  = {1'b0, xa} + {1'b0, ~yb} + 5'd1;
                            r  = {4'h0, s[3:0]};
                            co = s[4];
                        end
                        2: begin
                            r  = {4'h0, xa} * {4'h0, yb};
                            co = 1'b0;
                        end
                        default: begin
                            r  = 8'h00;
                            co = 1'b0;
                            er = 1'b1;
                        end
                    endcase
                    issue4(2'(o), xa, yb, ci, r, co, er);
                end
            end
        end

        t = 0;
        while ((q8.size() != 0 || q4.size() != 0) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (q8.size() != 0 || q4.size() != 0) fail("drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
